// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/status bundle between the multicycle MIPS controller and its datapath/memory
//   op, funct, zeroNzero, mem_ready   : datapath/memory -> controller
//   mem_req .. pcen, illegal_op       : controller -> datapath/memory
//   state_dbg                         : current controller state encoding
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zeroNzero;
  logic       mem_ready;
  logic       mem_req;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       illegal_op;
  logic [3:0] state_dbg;
  modport master (
    input  op, funct, zeroNzero, mem_ready,
    output mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal_op, state_dbg
  );
  modport slave (
    output op, funct, zeroNzero, mem_ready,
    input  mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal_op, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a multicycle MIPS datapath sharing one memory port
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, forces IDLE
//   bus   : multicycle_ctrl_if.master (decode inputs, memory handshake, datapath controls)
module multicycle_ctrl (
  input  logic clk,
  input  logic reset,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    RTYPEEX = 4'd7,
    RTYPEWB = 4'd8,
    BREX    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JEX     = 4'd12,
    JREX    = 4'd13
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  state_t     state_q, state_d;
  logic [2:0] rt_alu;
  logic       rt_ok;
  always_comb begin
    rt_ok = 1'b1;
    case (bus.funct)
      6'b100000: rt_alu = 3'b010;
      6'b100010: rt_alu = 3'b110;
      6'b100100: rt_alu = 3'b000;
      6'b100101: rt_alu = 3'b001;
      6'b101010: rt_alu = 3'b111;
      6'b000000: rt_alu = 3'b011;
      6'b000010: rt_alu = 3'b100;
      default: begin
        rt_alu = ALU_ADD;
        rt_ok  = 1'b0;
      end
    endcase
  end
  always_comb begin
    state_d        = IDLE;
    bus.mem_req    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.iord       = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regwrite   = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.alucontrol = 3'b000;
    bus.pcsrc      = 2'b00;
    bus.pcen       = 1'b0;
    bus.illegal_op = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        bus.mem_req    = 1'b1;
        bus.alusrcb    = 2'b01;
        bus.alucontrol = ALU_ADD;
        bus.irwrite    = bus.mem_ready;
        bus.pcen       = bus.mem_ready;
        state_d        = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alusrcb    = 2'b11;
        bus.alucontrol = ALU_ADD;
        case (bus.op)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = (bus.funct == 6'b001000) ? JREX : RTYPEEX;
          6'b000100, 6'b000101: state_d = BREX;
          6'b001000:            state_d = ADDIEX;
          6'b000010:            state_d = JEX;
          default: begin
            state_d        = FETCH;
            bus.illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.alusrca    = 1'b1;
        bus.alusrcb    = 2'b10;
        bus.alucontrol = ALU_ADD;
        // op bit 3 separates sw (101011) from lw (100011)
        state_d        = bus.op[3] ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        state_d     = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        bus.mem_req  = 1'b1;
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        state_d      = bus.mem_ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = rt_alu;
        bus.illegal_op = ~rt_ok;
        state_d        = rt_ok ? RTYPEWB : FETCH;
      end
      RTYPEWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
        state_d      = FETCH;
      end
      BREX: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ALU_SUB;
        bus.pcsrc      = 2'b01;
        bus.pcen       = bus.zeroNzero;
        state_d        = FETCH;
      end
      ADDIEX: begin
        bus.alusrca    = 1'b1;
        bus.alusrcb    = 2'b10;
        bus.alucontrol = ALU_ADD;
        state_d        = ADDIWB;
      end
      ADDIWB: begin
        bus.regwrite = 1'b1;
        state_d      = FETCH;
      end
      JEX: begin
        bus.pcsrc = 2'b10;
        bus.pcen  = 1'b1;
        state_d   = FETCH;
      end
      JREX: begin
        bus.pcsrc = 2'b11;
        bus.pcen  = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.state_dbg = state_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized checks of multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  multicycle_ctrl_if bus();
  multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010, JR_F = 6'b001000;
  logic [5:0] legal_f [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010};
  logic [2:0] alu_f   [7] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011, 3'b100};
  int path[$];
  logic [16:0] act;
  assign act = {bus.mem_req, bus.memwrite, bus.iord, bus.irwrite, bus.regwrite, bus.regdst,
                bus.memtoreg, bus.alusrca, bus.alusrcb, bus.alucontrol, bus.pcsrc, bus.pcen, bus.illegal_op};

  function automatic logic legal_funct(logic [5:0] f);
    for (int i = 0; i < 7; i++) if (legal_f[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] alu_of(logic [5:0] f);
    for (int i = 0; i < 7; i++) if (legal_f[i] == f) return alu_f[i];
    return 3'b010;
  endfunction

  // Sequence of states an instruction walks through, ignoring memory wait repeats
  function automatic void build_path(logic [5:0] o, logic [5:0] f);
    if (o == LW) path = {1, 2, 3, 4, 5};
    else if (o == SW) path = {1, 2, 3, 6};
    else if (o == RT && f == JR_F) path = {1, 2, 13};
    else if (o == RT && legal_funct(f)) path = {1, 2, 7, 8};
    else if (o == RT) path = {1, 2, 7};
    else if (o == BEQ || o == BNE) path = {1, 2, 9};
    else if (o == ADDI) path = {1, 2, 10, 11};
    else if (o == J) path = {1, 2, 12};
    else path = {1, 2};
  endfunction

  // Expected control word per state, packed in the same order as act
  function automatic logic [16:0] exp_out(int st, logic r, logic z, logic [5:0] o, logic [5:0] f);
    logic mreq = 0, mw = 0, io = 0, irw = 0, rw = 0, rd = 0, m2r = 0, asa = 0, pe = 0, ill = 0;
    logic [1:0] asb = 0, ps = 0;
    logic [2:0] ac = 0;
    case (st)
      1:  begin mreq = 1; asb = 2'b01; ac = 3'b010; irw = r; pe = r; end
      2:  begin asb = 2'b11; ac = 3'b010; ill = !(o inside {LW, SW, RT, BEQ, BNE, ADDI, J}); end
      3:  begin asa = 1; asb = 2'b10; ac = 3'b010; end
      4:  begin mreq = 1; io = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mreq = 1; mw = 1; io = 1; end
      7:  begin asa = 1; ac = alu_of(f); ill = !legal_funct(f); end
      8:  begin rw = 1; rd = 1; end
      9:  begin asa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      10: begin asa = 1; asb = 2'b10; ac = 3'b010; end
      11: rw = 1;
      12: begin ps = 2'b10; pe = 1; end
      13: begin ps = 2'b11; pe = 1; end
      default: ;
    endcase
    return {mreq, mw, io, irw, rw, rd, m2r, asa, asb, ac, ps, pe, ill};
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic r, logic z);
    bus.mem_ready = r;
    bus.zeroNzero = z;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) adv();
    total++;
    if (bus.state_dbg !== 4'd0 || act !== 17'd0) begin
      bad++; $display("FAIL reset_idle state=%0d outs=%h expected state=0 outs=0", bus.state_dbg, act);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.state_dbg !== 4'd0) begin
      bad++; $display("FAIL reset_release state=%0d expected 0", bus.state_dbg);
    end
    adv();
  endtask

  task automatic test_rtype();
    int st[5] = '{1, 2, 7, 8, 1};
    bus.op = RT; bus.funct = 6'b100000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) adv();
      drv(1'b1, 1'b0);
      total++;
      if (bus.state_dbg !== 4'(st[i]) || bus.regwrite !== (st[i] == 8) || bus.regdst !== (st[i] == 8) || bus.pcen !== (st[i] == 1)) begin
        bad++; $display("FAIL rtype cyc=%0d state=%0d rw=%b rd=%b pcen=%b expected state=%0d", i, bus.state_dbg, bus.regwrite, bus.regdst, bus.pcen, st[i]);
      end
    end
  endtask

  task automatic test_lw_wait();
    int   st[9]  = '{1, 2, 3, 4, 4, 4, 4, 5, 1};
    logic rdy[9] = '{1, 0, 1, 0, 0, 0, 1, 0, 1};
    bus.op = LW; bus.funct = 6'h15;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) adv();
      drv(rdy[i], 1'b1);
      total++;
      if (bus.state_dbg !== 4'(st[i])
          || (st[i] == 4 && {bus.mem_req, bus.iord, bus.irwrite, bus.pcen, bus.regwrite} !== 5'b11000)
          || (st[i] == 5 && {bus.memtoreg, bus.regwrite, bus.regdst} !== 3'b110)) begin
        bad++; $display("FAIL lw_wait cyc=%0d state=%0d req=%b iord=%b m2r=%b rw=%b expected state=%0d", i, bus.state_dbg, bus.mem_req, bus.iord, bus.memtoreg, bus.regwrite, st[i]);
      end
    end
  endtask

  task automatic test_branch();
    int st[4] = '{1, 2, 9, 1};
    for (int k = 0; k < 2; k++) begin
      logic z = (k == 0);
      bus.op = (k == 0) ? BEQ : BNE; bus.funct = 6'h00;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) adv();
        drv(1'b1, z);
        total++;
        if (bus.state_dbg !== 4'(st[i]) || (st[i] == 9 && (bus.pcen !== z || bus.pcsrc !== 2'b01))) begin
          bad++; $display("FAIL branch z=%b cyc=%0d state=%0d pcen=%b pcsrc=%b expected state=%0d", z, i, bus.state_dbg, bus.pcen, bus.pcsrc, st[i]);
        end
      end
    end
  endtask

  task automatic test_jumps();
    for (int k = 0; k < 2; k++) begin
      int st[4];
      logic [1:0] ps = (k == 0) ? 2'b11 : 2'b10;
      st = '{1, 2, (k == 0) ? 13 : 12, 1};
      bus.op = (k == 0) ? RT : J; bus.funct = (k == 0) ? JR_F : 6'h20;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) adv();
        drv(1'b1, 1'b0);
        total++;
        if (bus.state_dbg !== 4'(st[i]) || (i == 2 && (bus.pcsrc !== ps || bus.pcen !== 1'b1 || bus.regwrite !== 1'b0))) begin
          bad++; $display("FAIL jump k=%0d cyc=%0d state=%0d pcsrc=%b pcen=%b expected state=%0d pcsrc=%b", k, i, bus.state_dbg, bus.pcsrc, bus.pcen, st[i], ps);
        end
      end
    end
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 2; k++) begin
      int st[4];
      int n = (k == 0) ? 3 : 4;
      st = (k == 0) ? '{1, 2, 1, 0} : '{1, 2, 7, 1};
      bus.op = (k == 0) ? 6'b111111 : RT; bus.funct = 6'b111111;
      for (int i = 0; i < n; i++) begin
        if (i > 0) adv();
        drv(1'b1, 1'b0);
        total++;
        if (bus.state_dbg !== 4'(st[i]) || bus.illegal_op !== (i == n - 2) || bus.regwrite !== 1'b0) begin
          bad++; $display("FAIL illegal k=%0d cyc=%0d state=%0d ill=%b rw=%b expected state=%0d ill=%b", k, i, bus.state_dbg, bus.illegal_op, bus.regwrite, st[i], i == n - 2);
        end
      end
    end
  endtask

  task automatic test_reset_midaccess();
    int   st[4]  = '{1, 2, 3, 6};
    logic rdy[4] = '{1, 1, 1, 0};
    bus.op = SW; bus.funct = 6'h00;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) adv();
      drv(rdy[i], 1'b0);
      total++;
      if (bus.state_dbg !== 4'(st[i]) || (st[i] == 6 && {bus.mem_req, bus.memwrite, bus.iord} !== 3'b111)) begin
        bad++; $display("FAIL sw_wait cyc=%0d state=%0d req=%b mw=%b expected state=%0d", i, bus.state_dbg, bus.mem_req, bus.memwrite, st[i]);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.state_dbg !== 4'd0 || bus.mem_req !== 1'b0 || bus.memwrite !== 1'b0) begin
      bad++; $display("FAIL async_abort state=%0d req=%b mw=%b expected 0 0 0", bus.state_dbg, bus.mem_req, bus.memwrite);
    end
    bus.mem_ready = 1'b1;
    adv();
    total++;
    if (bus.state_dbg !== 4'd0 || act !== 17'd0) begin
      bad++; $display("FAIL held_reset state=%0d outs=%h expected 0", bus.state_dbg, act);
    end
    reset = 1'b1;
    adv();
    drv(1'b0, 1'b0);
    total++;
    if (bus.state_dbg !== 4'd1) begin
      bad++; $display("FAIL after_abort state=%0d expected 1", bus.state_dbg);
    end
  endtask

  task automatic test_random();
    int w;
    logic r, z;
    logic [5:0] o, f;
    for (int n = 0; n < 300; n++) begin
      f = 6'($urandom);
      case ($urandom_range(0, 7))
        0: o = LW;
        1: o = SW;
        2: begin o = RT; f = legal_f[$urandom_range(0, 6)]; end
        3: o = RT;
        4: o = $urandom_range(0, 1) ? BEQ : BNE;
        5: o = ADDI;
        6: o = J;
        default: begin
          o = 6'($urandom);
          while (o inside {LW, SW, RT, BEQ, BNE, ADDI, J}) o = 6'($urandom);
        end
      endcase
      bus.op = o; bus.funct = f;
      build_path(o, f);
      foreach (path[i]) begin
        w = (path[i] inside {1, 4, 6}) ? $urandom_range(0, 3) : 0;
        for (int c = 0; c <= w; c++) begin
          r = (path[i] inside {1, 4, 6}) ? (c == w) : 1'($urandom);
          z = 1'($urandom);
          drv(r, z);
          total++;
          if (bus.state_dbg !== 4'(path[i]) || act !== exp_out(path[i], r, z, o, f)) begin
            bad++; $display("FAIL random n=%0d op=%b funct=%b state=%0d outs=%h expected state=%0d outs=%h", n, o, f, bus.state_dbg, act, path[i], exp_out(path[i], r, z, o, f));
          end
          adv();
        end
      end
    end
    drv(1'b0, 1'b0);
    total++;
    if (bus.state_dbg !== 4'd1) begin
      bad++; $display("FAIL random_end state=%0d expected 1", bus.state_dbg);
    end
  endtask

  initial begin
    bus.op = 6'h00; bus.funct = 6'h00; bus.mem_ready = 1'b0; bus.zeroNzero = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_jumps();
    test_illegal();
    test_reset_midaccess();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath sharing one memory port for instruction fetch and load/store.
- Decodes opcode/funct from the instruction register and drives per-state mux selects, write enables and ALU control.
- Adds a memory wait-state handshake (mem_req/mem_ready).
- Branch decision consumes the datapath's combined zeroNzero flag, which already resolves beq vs bne.

Parameters:
- none; encodings below are fixed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0].
- zeroNzero  in  1  branch-taken flag from datapath.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- memwrite  out  1  access is a store.
- iord  out  1  memory address select: 0 = pc, 1 = aluout.
- irwrite  out  1  load instruction register.
- regwrite  out  1  register file write.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = load data to register file.
- alusrca  out  1  0 = pc, 1 = rs.
- alusrcb  out  2  00 = rt, 01 = const 4, 10 = signimm, 11 = signimm<<2.
- alucontrol  out  3  add 010, sub 110, and 000, or 001, slt 111, sll 011, srl 100.
- pcsrc  out  2  00 = ALU result, 01 = aluout (branch target), 10 = jump target, 11 = rs (jr).
- pcen  out  1  PC register enable.
- illegal_op  out  1  one-cycle pulse on unsupported opcode or funct.
- state_dbg  out  4  current state encoding.

Behaviour:
- **States and encodings:** IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, RTYPEEX 7, RTYPEWB 8, BREX 9, ADDIEX 10, ADDIWB 11, JEX 12, JREX 13.
- **Reset:** reset low forces IDLE immediately. All outputs are 0 while in IDLE. IDLE always advances to FETCH on the next edge.
- **FETCH:**
  - Outputs: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
  - irwrite and pcen assert only in the cycle where mem_ready=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- **DECODE:**
  - Outputs: alusrca=0, alusrcb=11, alucontrol=add (branch target into aluout).
  - Next state by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 -> JREX if funct=001000, else RTYPEEX.
    - 000100 (beq) or 000101 (bne) -> BREX.
    - 001000 (addi) -> ADDIEX.
    - 000010 (j) -> JEX.
    - Any other op -> FETCH with illegal_op=1 for this cycle.
- **MEMADR:** alusrca=1, alusrcb=10, add. Next: MEMRD for lw, MEMWR for sw.
- **MEMRD:** mem_req=1, iord=1. Hold until mem_ready, then -> MEMWB.
- **MEMWB:** regwrite=1, regdst=0, memtoreg=1. -> FETCH.
- **MEMWR:** mem_req=1, memwrite=1, iord=1. Hold until mem_ready, then -> FETCH.
- **RTYPEEX:**
  - Datapath selects: alusrca=1, alusrcb=00.
  - alucontrol by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll, 000010 srl.
  - Any other funct -> illegal_op=1, alucontrol=add, next FETCH with no writeback.
  - Otherwise -> RTYPEWB.
- **RTYPEWB:** regwrite=1, regdst=1, memtoreg=0. -> FETCH.
- **BREX:** alusrca=1, alusrcb=00, sub, pcsrc=01. pcen=zeroNzero. -> FETCH.
- **ADDIEX:** alusrca=1, alusrcb=10, add. -> ADDIWB.
- **ADDIWB:** regwrite=1, regdst=0, memtoreg=0. -> FETCH.
- **JEX:** pcsrc=10, pcen=1. -> FETCH.
- **JREX:** pcsrc=11, pcen=1. -> FETCH.
- **Outputs not listed for a state are 0.** All outputs are a combinational function of state (plus mem_ready, zeroNzero, op and funct only where stated). There is no output latency beyond the state register.
- **Cycle counts with zero wait states:**
  - lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3; jr 3.
  - Each memory wait cycle adds 1.
- **mem_ready handling:** ignored outside FETCH, MEMRD and MEMWR. While waiting, mem_req, iord and memwrite stay stable; irwrite and pcen stay 0.
- **Reset mid-access:** reset asserted in any state (including a wait) aborts to IDLE; no further write strobes are issued.
- **Undefined state encodings** (14, 15) -> IDLE on the next edge, all outputs 0.

Test Plan:
- Release reset with mem_ready=1, feed add (op 000000, funct 100000) -> states 0,1,2,7,8,1. regwrite=1 and regdst=1 only in state 8; pcen=1 only in state 1.
- lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_req=1, iord=1 constant. MEMWB follows with memtoreg=1 and regwrite=1. Total 8 cycles.
- beq: zeroNzero=1 in BREX -> pcen=1, pcsrc=01. Repeat with zeroNzero=0 -> pcen=0. FETCH follows in both cases.
- jr (funct 001000) -> JREX with pcsrc=11, pcen=1. j (op 000010) -> JEX with pcsrc=10. 3 cycles each.
- Unsupported op 111111 -> illegal_op pulses 1 cycle in DECODE, then FETCH. R-type funct 111111 -> pulse in RTYPEEX, no regwrite.
- Drive reset low during MEMWR wait -> memwrite and mem_req drop to 0 asynchronously, state_dbg=0. After release, the next state is FETCH.
